// File: rtl/bsg_manycore_pkg.sv
// Manycore packet macros and shared constants.
// Packet layout, MSB first: addr, op, op_ex, data, y_cord, x_cord.

`ifndef BSG_MANYCORE_PACKET_MACROS
`define BSG_MANYCORE_PACKET_MACROS

`define BSG_MANYCORE_PACKET_WIDTH(aw,dw,xw,yw) \
  (2+((dw)>>3)+(xw)+(yw)+(dw)+(aw))

`define DECLARE_BSG_MANYCORE_PACKET_S(aw,dw,xw,yw) \
  typedef struct packed { \
    logic [(aw)-1:0]      addr; \
    logic [1:0]           op; \
    logic [((dw)>>3)-1:0] op_ex; \
    logic [(dw)-1:0]      data; \
    logic [(yw)-1:0]      y_cord; \
    logic [(xw)-1:0]      x_cord; \
  } bsg_manycore_packet_s

`endif

package bsg_manycore_pkg;

  localparam logic [1:0] e_op_remote_store = 2'd1;
  localparam logic [1:0] e_op_config       = 2'd2;

  typedef enum logic [1:0] {
    e_cmd_store    = 2'd0,
    e_cmd_freeze   = 2'd1,
    e_cmd_unfreeze = 2'd2,
    e_cmd_illegal  = 2'd3
  } bsg_manycore_cmd_e;

  localparam int unsigned config_addr_gp = 0;

endpackage

// File: rtl/bsg_manycore_pkt_encode_if.sv
// Mesh link bundle: packet valid/data towards the
// network, ready back from it.

interface bsg_manycore_pkt_encode_if #(
  parameter int width_p = 68
);

  logic               v;
  logic [width_p-1:0] data;
  logic               ready;

  modport master (
    output v,
    output data,
    input  ready
  );

  modport slave (
    input  v,
    input  data,
    output ready
  );

endinterface

// File: rtl/bsg_manycore_pkt_credit_counter.sv
// Outstanding-request credit counter, saturating at
// its reset value; flags a return that would overflow.

module bsg_manycore_pkt_credit_counter #(
  parameter  int max_val_p = 4,
  localparam int width_lp  = $clog2(max_val_p+1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                spend_i,
  input  logic                return_i,
  output logic [width_lp-1:0] count_o,
  output logic                overflow_o
);

  localparam logic [width_lp-1:0] lp_max =
    width_lp'(max_val_p);

  logic [width_lp-1:0] r_count;
  logic [width_lp-1:0] w_count_nxt;
  logic                w_dn;
  logic                w_up;
  logic                w_sat;

  assign w_dn = spend_i & ~return_i
              & (r_count != '0);
  assign w_up = return_i & ~spend_i
              & (r_count != lp_max);
  assign w_sat = return_i & ~spend_i
               & (r_count == lp_max);

  assign count_o    = r_count;
  assign overflow_o = w_sat;

  // one step per cycle; spend+return cancels out
  always_comb begin
    w_count_nxt = r_count;
    unique case (1'b1)
      w_dn:    w_count_nxt = r_count - width_lp'(1);
      w_up:    w_count_nxt = r_count + width_lp'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // count register, full credit out of reset
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_count <= lp_max;
    else            r_count <= w_count_nxt;
  end

  // a return at full credit means the network lost track
  always_ff @(posedge clk_i) begin
    if (reset_n_i)
      assert (!w_sat)
        else $warning("credit return ignored at max count");
  end

endmodule

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO, valid/ready in, valid/yumi out.
// No enqueue-to-output bypass; ready_o is pure state.

module bsg_two_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] r_mem [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_cnt;
  logic               w_enq;
  logic               w_deq;

  assign ready_o = (r_cnt != 2'd2);
  assign v_o     = (r_cnt != 2'd0);
  assign data_o  = r_mem[r_rd_ptr];
  assign w_enq   = v_i & ready_o;
  assign w_deq   = yumi_i & v_o;

  // occupancy and pointers; cleared asynchronously
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_enq) r_wr_ptr <= ~r_wr_ptr;
      if (w_deq) r_rd_ptr <= ~r_rd_ptr;
      unique case ({w_enq, w_deq})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // storage; contents are only meaningful while counted
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/bsg_manycore_pkt_encode.sv
// Endpoint command to manycore packet encoder with
// a 2-entry output FIFO and outstanding-credit gating.

module bsg_manycore_pkt_encode
  import bsg_manycore_pkg::*;
#(
  parameter  int x_cord_width_p    = 5,
  parameter  int y_cord_width_p    = 5,
  parameter  int data_width_p      = 32,
  parameter  int addr_width_p      = 20,
  parameter  int max_out_credits_p = 4,
  localparam int packet_width_lp   =
    `BSG_MANYCORE_PACKET_WIDTH(addr_width_p,
      data_width_p, x_cord_width_p, y_cord_width_p),
  localparam int credit_width_lp   =
    $clog2(max_out_credits_p+1)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic [1:0]                 cmd_i,
  input  logic [addr_width_p-1:0]    addr_i,
  input  logic [data_width_p-1:0]    data_i,
  input  logic [(data_width_p>>3)-1:0] mask_i,
  input  logic [x_cord_width_p-1:0]  x_cord_i,
  input  logic [y_cord_width_p-1:0]  y_cord_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [packet_width_lp-1:0] data_o,
  input  logic                       ready_i,
  input  logic                       credit_i,
  output logic [credit_width_lp-1:0] credits_o,
  output logic                       err_o
);

  `DECLARE_BSG_MANYCORE_PACKET_S(addr_width_p,
    data_width_p, x_cord_width_p, y_cord_width_p);

  if ((data_width_p % 8) != 0) begin : g_bad_dw
    $error("data_width_p must be a multiple of 8");
  end
  if (max_out_credits_p < 1) begin : g_bad_cr
    $error("max_out_credits_p must be at least 1");
  end

  bsg_manycore_cmd_e    w_cmd;
  bsg_manycore_packet_s w_pkt;
  logic                 w_fifo_ready;
  logic                 w_have_credit;
  logic                 w_accept;
  logic                 w_is_store;
  logic                 w_is_freeze;
  logic                 w_is_unfreeze;
  logic                 w_is_illegal;
  logic                 w_enq;
  logic                 w_ovf;
  logic                 r_err;

  assign w_cmd = bsg_manycore_cmd_e'(cmd_i);

  assign w_have_credit = (credits_o != '0);
  assign ready_o  = w_fifo_ready & w_have_credit;
  assign w_accept = v_i & ready_o;

  assign w_is_store    = (w_cmd == e_cmd_store);
  assign w_is_freeze   = (w_cmd == e_cmd_freeze);
  assign w_is_unfreeze = (w_cmd == e_cmd_unfreeze);
  assign w_is_illegal  = (w_cmd == e_cmd_illegal);

  assign w_enq = w_accept & ~w_is_illegal;

  assign err_o = r_err;

  // packet assembly; freeze/unfreeze are config writes
  always_comb begin
    w_pkt        = '0;
    w_pkt.x_cord = x_cord_i;
    w_pkt.y_cord = y_cord_i;
    unique case (1'b1)
      w_is_store: begin
        w_pkt.op    = e_op_remote_store;
        w_pkt.op_ex = mask_i;
        w_pkt.addr  = addr_i;
        w_pkt.data  = data_i;
      end
      w_is_freeze: begin
        w_pkt.op    = e_op_config;
        w_pkt.addr  = addr_width_p'(config_addr_gp);
        w_pkt.data  = data_width_p'(1);
      end
      w_is_unfreeze: begin
        w_pkt.op    = e_op_config;
        w_pkt.addr  = addr_width_p'(config_addr_gp);
        w_pkt.data  = '0;
      end
      default: w_pkt.op = 2'd0;
    endcase
  end

  bsg_two_fifo #(
    .width_p (packet_width_lp)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .ready_o   (w_fifo_ready),
    .data_i    (w_pkt),
    .v_i       (w_enq),
    .v_o       (v_o),
    .data_o    (data_o),
    .yumi_i    (v_o & ready_i)
  );

  bsg_manycore_pkt_credit_counter #(
    .max_val_p (max_out_credits_p)
  ) u_credits (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .spend_i    (w_enq),
    .return_i   (credit_i),
    .count_o    (credits_o),
    .overflow_o (w_ovf)
  );

  // error pulse one cycle after a dropped command
  // or an overflowing credit return
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_err <= 1'b0;
    else            r_err <= (w_accept & w_is_illegal)
                           | w_ovf;
  end

endmodule

// File: tb/tb_bsg_manycore_pkt_encode.sv
// Bench for the manycore packet encoder: directed
// vector table, reset corner, then random vs model.

module tb_bsg_manycore_pkt_encode;
  import bsg_manycore_pkg::*;

  localparam int XW = 5;
  localparam int YW = 5;
  localparam int DW = 32;
  localparam int AW = 20;
  localparam int MC = 4;
  localparam int MW = DW/8;
  localparam int PW = AW+2+MW+DW+YW+XW;
  localparam int CW = $clog2(MC+1);

  typedef struct packed {
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } cmd_t;

  typedef struct {
    bit   v;
    cmd_t c;
    bit   rdy;
    bit   cr;
    bit   e_ready;
    bit   e_v;
    cmd_t e_c;
    int   e_cred;
    bit   e_err;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          v_i = 1'b0;
  logic [1:0]    cmd_i = '0;
  logic [AW-1:0] addr_i = '0;
  logic [DW-1:0] data_i = '0;
  logic [MW-1:0] mask_i = '0;
  logic [XW-1:0] x_i = '0;
  logic [YW-1:0] y_i = '0;
  logic          ready_o;
  logic          credit_i = 1'b0;
  logic [CW-1:0] credits_o;
  logic          err_o;

  bsg_manycore_pkt_encode_if #(.width_p(PW)) link();

  always #5 clk = ~clk;

  bsg_manycore_pkt_encode dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .v_i       (v_i),
    .cmd_i     (cmd_i),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .mask_i    (mask_i),
    .x_cord_i  (x_i),
    .y_cord_i  (y_i),
    .ready_o   (ready_o),
    .v_o       (link.v),
    .data_o    (link.data),
    .ready_i   (link.ready),
    .credit_i  (credit_i),
    .credits_o (credits_o),
    .err_o     (err_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [PW-1:0] act,
                     logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // expected packet from the command rules
  function automatic logic [PW-1:0] pkt(cmd_t c);
    logic [1:0]    op;
    logic [MW-1:0] ex;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    op = 2'd2; ex = '0; a = '0; d = '0;
    if (c.cmd == 2'd0) begin
      op = 2'd1; ex = c.mask; a = c.addr; d = c.data;
    end else if (c.cmd == 2'd1) begin
      d = 1;
    end
    return {a, op, ex, d, c.y, c.x};
  endfunction

  function automatic cmd_t st(int x, int y, int a,
                              logic [DW-1:0] d, int m);
    cmd_t c;
    c.cmd = 2'd0; c.addr = AW'(a); c.data = d;
    c.mask = MW'(m); c.x = XW'(x); c.y = YW'(y);
    return c;
  endfunction

  function automatic cmd_t cf(int k, int x, int y);
    cmd_t c;
    c = '0;
    c.cmd = 2'(k); c.x = XW'(x); c.y = YW'(y);
    c.addr = AW'(32'h5A5A5); c.data = 32'hCAFE0000;
    c.mask = '1;
    return c;
  endfunction

  function automatic vec_t mk(bit v, cmd_t c, bit rdy,
    bit cr, bit er, bit ev, cmd_t ec, int ecr, bit ee);
    vec_t t;
    t.v = v; t.c = c; t.rdy = rdy; t.cr = cr;
    t.e_ready = er; t.e_v = ev; t.e_c = ec;
    t.e_cred = ecr; t.e_err = ee;
    return t;
  endfunction

  task automatic drive(bit v, cmd_t c, bit rdy, bit cr);
    v_i = v; cmd_i = c.cmd; addr_i = c.addr;
    data_i = c.data; mask_i = c.mask;
    x_i = c.x; y_i = c.y;
    link.ready = rdy; credit_i = cr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  vec_t tv[$];
  cmd_t I, P1, PF, PU, S1, S2, S3, U1, C;
  cmd_t T[6];

  logic [PW-1:0] m_q[$];
  int            m_cred;
  bit            m_err;

  initial begin
    link.ready = 1'b0;
    I  = '0;
    P1 = st(3, 2, 'h00123, 32'hDEADBEEF, 'hF);
    PF = cf(1, 1, 1);
    PU = cf(2, 1, 1);
    S1 = st(4, 7, 'h11111, 32'h01020304, 'h1);
    S2 = st(5, 8, 'h22222, 32'h05060708, 'h3);
    S3 = st(6, 9, 'h33333, 32'h090A0B0C, 'h7);
    U1 = st(31, 31, 'hFFFFF, 32'hFFFFFFFF, 'hA);
    for (int i = 0; i < 6; i++)
      T[i] = st(i, 30-i, 'h40000+i, 32'h1000+i, i+1);

    // store, then freeze/unfreeze in order
    tv.push_back(mk(1,P1,1,0, 1,1,P1,3,0));
    tv.push_back(mk(0,I ,1,0, 1,0,I ,3,0));
    tv.push_back(mk(1,PF,1,0, 1,1,PF,2,0));
    tv.push_back(mk(1,PU,1,0, 1,1,PU,1,0));
    tv.push_back(mk(0,I ,1,1, 1,0,I ,2,0));
    tv.push_back(mk(0,I ,1,1, 1,0,I ,3,0));
    tv.push_back(mk(0,I ,1,1, 1,0,I ,4,0));
    tv.push_back(mk(0,I ,1,0, 1,0,I ,4,0));
    // backpressure: fill, hold, no bypass, drain
    tv.push_back(mk(1,S1,0,0, 1,1,S1,3,0));
    tv.push_back(mk(1,S2,0,0, 0,1,S1,2,0));
    tv.push_back(mk(1,S3,0,0, 0,1,S1,2,0));
    tv.push_back(mk(1,S3,0,0, 0,1,S1,2,0));
    tv.push_back(mk(1,S3,1,0, 1,1,S2,2,0));
    tv.push_back(mk(1,S3,1,0, 1,1,S3,1,0));
    tv.push_back(mk(0,I ,1,0, 1,0,I ,1,0));
    tv.push_back(mk(0,I ,1,1, 1,0,I ,2,0));
    tv.push_back(mk(0,I ,1,1, 1,0,I ,3,0));
    tv.push_back(mk(0,I ,1,1, 1,0,I ,4,0));
    // credit exhaustion and single-credit reopen
    tv.push_back(mk(1,T[0],1,0, 1,1,T[0],3,0));
    tv.push_back(mk(1,T[1],1,0, 1,1,T[1],2,0));
    tv.push_back(mk(1,T[2],1,0, 1,1,T[2],1,0));
    tv.push_back(mk(1,T[3],1,0, 0,1,T[3],0,0));
    tv.push_back(mk(1,T[4],1,0, 0,0,I   ,0,0));
    tv.push_back(mk(1,T[4],1,1, 1,0,I   ,1,0));
    tv.push_back(mk(1,T[4],1,0, 0,1,T[4],0,0));
    tv.push_back(mk(1,T[5],1,0, 0,0,I   ,0,0));
    tv.push_back(mk(0,I ,1,1, 1,0,I ,1,0));
    tv.push_back(mk(0,I ,1,1, 1,0,I ,2,0));
    tv.push_back(mk(0,I ,1,1, 1,0,I ,3,0));
    tv.push_back(mk(0,I ,1,1, 1,0,I ,4,0));
    // illegal command, overflow, spend+return
    C = cf(3, 2, 2);
    tv.push_back(mk(1,C ,1,0, 1,0,I ,4,1));
    tv.push_back(mk(0,I ,1,0, 1,0,I ,4,0));
    tv.push_back(mk(0,I ,1,1, 1,0,I ,4,1));
    tv.push_back(mk(0,I ,1,0, 1,0,I ,4,0));
    tv.push_back(mk(1,U1,1,1, 1,1,U1,4,0));
    tv.push_back(mk(0,I ,1,0, 1,0,I ,4,0));

    do_reset();
    chk("reset v_o", PW'(link.v), PW'(0));
    chk("reset credits", PW'(credits_o), PW'(MC));
    chk("reset err", PW'(err_o), PW'(0));
    chk("reset ready", PW'(ready_o), PW'(1));

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].v, tv[i].c, tv[i].rdy, tv[i].cr);
      step();
      chk($sformatf("r%0d ready", i),
          PW'(ready_o), PW'(tv[i].e_ready));
      chk($sformatf("r%0d v_o", i),
          PW'(link.v), PW'(tv[i].e_v));
      chk($sformatf("r%0d credits", i),
          PW'(credits_o), PW'(tv[i].e_cred));
      chk($sformatf("r%0d err", i),
          PW'(err_o), PW'(tv[i].e_err));
      if (tv[i].e_v)
        chk($sformatf("r%0d data", i),
            link.data, pkt(tv[i].e_c));
    end

    // asynchronous reset with two packets queued
    drive(1'b1, S1, 1'b0, 1'b0);
    step();
    drive(1'b1, S2, 1'b0, 1'b0);
    step();
    drive(1'b0, I, 1'b0, 1'b0);
    chk("queued v_o", PW'(link.v), PW'(1));
    chk("queued credits", PW'(credits_o), PW'(2));
    #2 reset_n = 1'b0;
    #1;
    chk("async v_o", PW'(link.v), PW'(0));
    chk("async credits", PW'(credits_o), PW'(MC));
    step();
    @(negedge clk);
    reset_n = 1'b1;
    link.ready = 1'b1;
    step();
    chk("post v_o", PW'(link.v), PW'(0));
    chk("post credits", PW'(credits_o), PW'(MC));
    chk("post ready", PW'(ready_o), PW'(1));
    chk("post err", PW'(err_o), PW'(0));

    // random traffic against a queue/credit model
    do_reset();
    m_q.delete();
    m_cred = MC;
    m_err  = 1'b0;
    for (int n = 0; n < 600; n++) begin
      cmd_t c;
      bit v, rdy, cr, acc, enq, deq;
      c.cmd  = ($urandom_range(0, 9) == 0) ?
               2'd3 : 2'($urandom_range(0, 2));
      c.addr = AW'($urandom);
      c.data = $urandom;
      c.mask = MW'($urandom);
      c.x    = XW'($urandom);
      c.y    = YW'($urandom);
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      cr  = (m_cred < MC) &&
            ($urandom_range(0, 2) == 0);
      acc = v && (m_q.size() < 2) && (m_cred > 0);
      enq = acc && (c.cmd != 2'd3);
      deq = (m_q.size() > 0) && rdy;
      drive(v, c, rdy, cr);
      if (deq) void'(m_q.pop_front());
      if (enq) m_q.push_back(pkt(c));
      m_cred = m_cred - int'(enq) + int'(cr);
      m_err  = acc && (c.cmd == 2'd3);
      step();
      chk("rnd ready", PW'(ready_o),
          PW'((m_q.size() < 2) && (m_cred > 0)));
      chk("rnd v_o", PW'(link.v), PW'(m_q.size() > 0));
      chk("rnd credits", PW'(credits_o), PW'(m_cred));
      chk("rnd err", PW'(err_o), PW'(m_err));
      if (m_q.size() > 0)
        chk("rnd data", link.data, m_q[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
